// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator, one transaction in flight: PL command in, AXI-Lite read/write out, response record back.
// Latency: 3 cycles command-to-response minimum; cmd_ready only in IDLE; every valid holds until its handshake.
module axi_lite_cmd_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  m00_axi_aclk,
   input  logic                  m00_axi_areset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [31:0]           cmd_wdata,
   input  logic [3:0]            cmd_wstrb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_write,
   output logic [31:0]           rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic                  err_sticky,
   input  logic                  err_clear,
   output logic [CNT_WIDTH-1:0]  txn_count,
   output logic [ADDR_WIDTH-1:0] m00_axi_awaddr,
   output logic [2:0]            m00_axi_awprot,
   output logic                  m00_axi_awvalid,
   input  logic                  m00_axi_awready,
   output logic [31:0]           m00_axi_wdata,
   output logic [3:0]            m00_axi_wstrb,
   output logic                  m00_axi_wvalid,
   input  logic                  m00_axi_wready,
   input  logic [1:0]            m00_axi_bresp,
   input  logic                  m00_axi_bvalid,
   output logic                  m00_axi_bready,
   output logic [ADDR_WIDTH-1:0] m00_axi_araddr,
   output logic [2:0]            m00_axi_arprot,
   output logic                  m00_axi_arvalid,
   input  logic                  m00_axi_arready,
   input  logic [31:0]           m00_axi_rdata,
   input  logic [1:0]            m00_axi_rresp,
   input  logic                  m00_axi_rvalid,
   output logic                  m00_axi_rready
);

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP} state_t;

   typedef struct packed {
      logic                  write;
      logic [ADDR_WIDTH-1:0] addr;
      logic [31:0]           wdata;
      logic [3:0]            wstrb;
   } cmd_t;

   state_t     state;
   cmd_t       cmd;
   logic       aw_done;
   logic       w_done;
   logic       aw_fire;
   logic       w_fire;
   logic       cap_fire;
   logic [1:0] cap_resp;

   assign aw_fire  = m00_axi_awvalid && m00_axi_awready;
   assign w_fire   = m00_axi_wvalid && m00_axi_wready;
   assign cap_fire = (m00_axi_bready && m00_axi_bvalid) || (m00_axi_rready && m00_axi_rvalid);
   assign cap_resp = m00_axi_bready ? m00_axi_bresp : m00_axi_rresp;

   // Address/data come straight from the command latch, which only changes in IDLE.
   assign m00_axi_awaddr = cmd.addr;
   assign m00_axi_araddr = cmd.addr;
   assign m00_axi_wdata  = cmd.wdata;
   assign m00_axi_wstrb  = cmd.wstrb;
   assign m00_axi_awprot = 3'b000;
   assign m00_axi_arprot = 3'b000;

   always_ff @(posedge m00_axi_aclk) begin
      if (m00_axi_areset) begin
         state           <= IDLE;
         cmd             <= '0;
         aw_done         <= 1'b0;
         w_done          <= 1'b0;
         cmd_ready       <= 1'b0;
         m00_axi_awvalid <= 1'b0;
         m00_axi_wvalid  <= 1'b0;
         m00_axi_bready  <= 1'b0;
         m00_axi_arvalid <= 1'b0;
         m00_axi_rready  <= 1'b0;
         rsp_valid       <= 1'b0;
         rsp_write       <= 1'b0;
         rsp_rdata       <= '0;
         rsp_resp        <= 2'b00;
         txn_count       <= '0;
      end else begin
         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_ready && cmd_valid) begin
                  cmd_ready <= 1'b0;
                  cmd.write <= cmd_write;
                  cmd.addr  <= {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
                  cmd.wdata <= cmd_wdata;
                  cmd.wstrb <= cmd_wstrb;
                  aw_done   <= 1'b0;
                  w_done    <= 1'b0;
                  if (cmd_write) begin
                     state           <= WR_REQ;
                     m00_axi_awvalid <= 1'b1;
                     m00_axi_wvalid  <= 1'b1;
                  end else begin
                     state           <= RD_REQ;
                     m00_axi_arvalid <= 1'b1;
                  end
               end
            end
            WR_REQ: begin
               if (aw_fire) begin
                  m00_axi_awvalid <= 1'b0;
                  aw_done         <= 1'b1;
               end
               if (w_fire) begin
                  m00_axi_wvalid <= 1'b0;
                  w_done         <= 1'b1;
               end
               // The two channels complete independently, possibly on the same edge.
               if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                  state          <= WR_RESP;
                  m00_axi_bready <= 1'b1;
               end
            end
            WR_RESP: begin
               if (m00_axi_bvalid) begin
                  m00_axi_bready <= 1'b0;
                  rsp_valid      <= 1'b1;
                  rsp_write      <= cmd.write;
                  rsp_rdata      <= '0;
                  rsp_resp       <= m00_axi_bresp;
                  state          <= RESP;
               end
            end
            RD_REQ: begin
               if (m00_axi_arready) begin
                  m00_axi_arvalid <= 1'b0;
                  m00_axi_rready  <= 1'b1;
                  state           <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (m00_axi_rvalid) begin
                  m00_axi_rready <= 1'b0;
                  rsp_valid      <= 1'b1;
                  rsp_write      <= cmd.write;
                  rsp_rdata      <= m00_axi_rdata;
                  rsp_resp       <= m00_axi_rresp;
                  state          <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  txn_count <= txn_count + CNT_WIDTH'(1);
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A fresh error outranks a simultaneous clear so no error is ever lost.
   always_ff @(posedge m00_axi_aclk) begin
      if (m00_axi_areset)
         err_sticky <= 1'b0;
      else if (cap_fire && cap_resp != 2'b00)
         err_sticky <= 1'b1;
      else if (err_clear)
         err_sticky <= 1'b0;
   end

endmodule

// File: doc/axi_lite_cmd_master.md
# axi_lite_cmd_master

AXI4-Lite initiator that converts single-word read/write commands from PL logic into AXI4-Lite transactions on an `m00_axi_*` master port. It drives the `s00_axi_*` slave port of the SNN weight/spike BRAM bridge, or any other AXI-Lite register slave, so that PL-side sequencers can preload or read back memory without the PS. Exactly one transaction is in flight at a time. Each completed transaction returns a response record to the command source.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: width of the AXI address and of `cmd_addr`.
- `CNT_WIDTH`, default 16: width of the completed-transaction counter.

Ports, in the order name, direction, width, meaning:
- `m00_axi_aclk` in 1: single clock for all logic.
- `m00_axi_areset` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1; `cmd_ready` out 1: command handshake.
- `cmd_write` in 1: 1 selects write, 0 selects read.
- `cmd_addr` in ADDR_WIDTH: byte address; bits [1:0] are ignored.
- `cmd_wdata` in 32; `cmd_wstrb` in 4: write payload.
- `rsp_valid` out 1; `rsp_ready` in 1: response handshake.
- `rsp_write` out 1: echo of `cmd_write` for this response.
- `rsp_rdata` out 32: read data; 0 for writes.
- `rsp_resp` out 2: BRESP or RRESP as captured.
- `err_sticky` out 1; `err_clear` in 1: sticky error flag and its clear.
- `txn_count` out CNT_WIDTH: number of responses delivered.
- Write address channel: `m00_axi_awaddr` out ADDR_WIDTH, `m00_axi_awprot` out 3, `m00_axi_awvalid` out 1, `m00_axi_awready` in 1.
- Write data channel: `m00_axi_wdata` out 32, `m00_axi_wstrb` out 4, `m00_axi_wvalid` out 1, `m00_axi_wready` in 1.
- Write response channel: `m00_axi_bresp` in 2, `m00_axi_bvalid` in 1, `m00_axi_bready` out 1.
- Read address channel: `m00_axi_araddr` out ADDR_WIDTH, `m00_axi_arprot` out 3, `m00_axi_arvalid` out 1, `m00_axi_arready` in 1.
- Read data channel: `m00_axi_rdata` in 32, `m00_axi_rresp` in 2, `m00_axi_rvalid` in 1, `m00_axi_rready` out 1.

## Operation
- The FSM has six states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch addr/wdata/wstrb/write. Latched address has bits [1:0] forced to 0.
  - Next state is WR_REQ for a write, RD_REQ for a read.
- WR_REQ:
  - `awvalid` and `wvalid` are asserted on state entry and tracked by independent done flags.
  - Each valid deasserts the cycle after its own handshake.
  - AW and W may complete in the same cycle or in either order.
  - Once both are done (including completion in the same cycle), go to WR_RESP.
- WR_RESP: `bready`=1; on `bvalid`, capture `bresp` and go to RESP.
- RD_REQ: `arvalid`=1; on `arready`, go to RD_DATA.
- RD_DATA: `rready`=1; on `rvalid`, capture `rdata` and `rresp` and go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_*` fields are held stable.
  - On `rsp_ready`, go to IDLE and increment `txn_count`, which wraps modulo 2^CNT_WIDTH.
- AXI valid signals never deassert before their handshake.
- Address and data outputs stay stable while the corresponding valid is high.
- `awprot` and `arprot` are constant 3'b000.
- All AXI outputs are registered or decoded from the state register. There is no combinational path from AXI inputs to AXI outputs.
- `err_sticky`:
  - Set when a captured resp is nonzero, at the capture edge.
  - Cleared by `err_clear`.
  - If set and clear occur in the same cycle, set wins.
- Reset asserted at any time:
  - Next state is IDLE.
  - All valid/ready outputs go to 0, `rsp_*` fields to 0, `err_sticky`=0, `txn_count`=0.
  - Any in-flight transaction is abandoned; the system resets the slave in the same cycle.

## Timing
- Reset values: every output is 0, including `cmd_ready`. `cmd_ready`=1 from the first cycle after reset deasserts.
- Minimum write latency, with cmd accepted at edge 0:
  - `awvalid` and `wvalid` are high in cycle 1.
  - With ready=1 in cycle 1, `bready` is high in cycle 2.
  - With `bvalid` in cycle 2, `rsp_valid` is high in cycle 3.
- Minimum read latency follows the same pattern: `arvalid` in cycle 1, `rready` in cycle 2, `rsp_valid` in cycle 3.
- Throughput: at most one transaction per 4 cycles, because `cmd_ready` is high only in IDLE.
- There is no bound on slave stalls and no timeout; the FSM waits indefinitely.

## Test plan
- **Write, all ready:** write 0x0000_0010 / 0xDEADBEEF / 4'hF with all readys and `bvalid` tied 1 -> AW and W each seen exactly once with `awaddr`=0x10; `rsp_valid` in cycle 3 with `rsp_resp`=0, `rsp_rdata`=0; `txn_count`=1.
- **Split write handshakes:** `wready` delayed 5 cycles after `awready` -> `awvalid` drops after cycle 1 and `wvalid` stays high until its handshake. Repeat with AW delayed instead. `bready` rises only after both handshakes.
- **Read, unaligned address:** read at 0x0000_0007, `rvalid` delayed 3 cycles, `rdata`=0x12345678 -> `araddr`=0x4; `rsp_rdata`=0x12345678 and `rsp_write`=0.
- **Back-pressure and error:** hold `rsp_ready`=0 for 4 cycles with `bresp`=2'b10 -> `rsp_*` held stable and `cmd_ready`=0 throughout; `err_sticky`=1. Assert `err_clear` on the same cycle as a new error capture -> `err_sticky` stays 1.
- **Reset mid-read:** assert reset during RD_DATA -> all valids/readys 0 on the next edge; `txn_count`=0; `cmd_ready`=1 one cycle after release.
- **Counter wrap:** with CNT_WIDTH=4, run 17 transactions -> `txn_count`=1.
